// File: rtl/sort_pkg.sv
// Shared types and helpers for the in-place selection-sort controller.
package sort_pkg;

   localparam int unsigned SORT_K_DEFAULT = 8;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_INIT_I   = 4'd1,
      S_LOAD_A   = 4'd2,
      S_INIT_J   = 4'd3,
      S_LOAD_B   = 4'd4,
      S_CMP      = 4'd5,
      S_WR_I     = 4'd6,
      S_WR_J     = 4'd7,
      S_RELOAD_A = 4'd8,
      S_NEXT_J   = 4'd9,
      S_NEXT_I   = 4'd10,
      S_DONE     = 4'd11
   } sort_state_t;

   typedef struct packed {
      logic ea;
      logic eb;
      logic li;
      logic ei;
      logic lj;
      logic ej;
      logic csel;
      logic we;
      logic bout;
      logic busy;
      logic done;
   } sort_ctrl_t;

   function automatic int unsigned max_swaps(input int unsigned k);
      return (k * (k - 1)) / 2;
   endfunction

   // Control word for a state; zi/zj are stable for the whole NEXT_I/NEXT_J cycle.
   function automatic sort_ctrl_t decode(input sort_state_t s, input logic zi, input logic zj);
      sort_ctrl_t c;
      c = '0;
      unique case (s)
         S_INIT_I:   c.li = 1'b1;
         S_LOAD_A:   c.ea = 1'b1;
         S_INIT_J:   c.lj = 1'b1;
         S_LOAD_B:   begin c.csel = 1'b1; c.eb = 1'b1; end
         S_WR_I:     begin c.bout = 1'b1; c.we = 1'b1; end
         S_WR_J:     begin c.csel = 1'b1; c.we = 1'b1; end
         S_RELOAD_A: c.ea = 1'b1;
         S_NEXT_J:   c.ej = ~zj;
         S_NEXT_I:   c.ei = ~zi;
         S_DONE:     c.done = 1'b1;
         default:    c = '0;
      endcase
      c.busy = (s != S_IDLE) && (s != S_DONE);
      return c;
   endfunction

endpackage

// File: rtl/sort_controller.sv
// Moore sequencer for a swap-on-compare selection sort over a K-entry memory.
// Optional swap counter enabled by SORT_CTRL_SWAP_CNT_EN.
module sort_controller
   import sort_pkg::*;
#(
   parameter int unsigned K      = SORT_K_DEFAULT,
   parameter int unsigned SWAP_W = $clog2(max_swaps(K) + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              AgtB,
   input  logic              zi,
   input  logic              zj,
   output logic              EA,
   output logic              EB,
   output logic              Li,
   output logic              Ei,
   output logic              Lj,
   output logic              Ej,
   output logic              Csel,
   output logic              WE,
   output logic              Bout,
   output logic              busy,
   output logic              done
`ifdef SORT_CTRL_SWAP_CNT_EN
   ,
   output logic [SWAP_W-1:0] swap_cnt
`endif
);

   if (K < 2 || SWAP_W < $clog2(max_swaps(K) + 1)) begin : g_bad_cfg
      $error("sort_controller: K must be >= 2 and SWAP_W wide enough for K*(K-1)/2");
   end

   sort_state_t state_q, state_d;
   sort_ctrl_t  ctrl_q, ctrl_d;

   // Next state, and the control word of that next state so outputs come straight from flops.
   always_comb begin
      state_d = state_q;
      ctrl_d  = '0;
      unique case (state_q)
         S_IDLE:     if (start) state_d = S_INIT_I;
         S_INIT_I:   state_d = S_LOAD_A;
         S_LOAD_A:   state_d = S_INIT_J;
         S_INIT_J:   state_d = S_LOAD_B;
         S_LOAD_B:   state_d = S_CMP;
         S_CMP:      state_d = AgtB ? S_WR_I : S_NEXT_J;
         S_WR_I:     state_d = S_WR_J;
         S_WR_J:     state_d = S_RELOAD_A;
         S_RELOAD_A: state_d = S_NEXT_J;
         S_NEXT_J:   state_d = zj ? S_NEXT_I : S_LOAD_B;
         S_NEXT_I:   state_d = zi ? S_DONE : S_LOAD_A;
         S_DONE:     if (!start) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      ctrl_d = decode(state_d, zi, zj);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign EA   = ctrl_q.ea;
   assign EB   = ctrl_q.eb;
   assign Li   = ctrl_q.li;
   assign Ei   = ctrl_q.ei;
   assign Lj   = ctrl_q.lj;
   assign Ej   = ctrl_q.ej;
   assign Csel = ctrl_q.csel;
   assign WE   = ctrl_q.we;
   assign Bout = ctrl_q.bout;
   assign busy = ctrl_q.busy;
   assign done = ctrl_q.done;

`ifdef SORT_CTRL_SWAP_CNT_EN
   logic [SWAP_W-1:0] swap_cnt_q;

   // One swap per WR_I cycle; value survives DONE/IDLE until the next sort begins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         swap_cnt_q <= '0;
      end else if (state_q == S_INIT_I) begin
         swap_cnt_q <= '0;
      end else if (state_q == S_WR_I) begin
         swap_cnt_q <= swap_cnt_q + SWAP_W'(1);
      end
   end

   assign swap_cnt = swap_cnt_q;
`endif

endmodule

// File: tb/tb_sort_controller.sv
// Self-checking bench: behavioural datapath + memory around sort_controller, directed vectors.
module tb_sort_controller;

   localparam int unsigned K = 8;

   typedef logic [7:0] mem_t [K];

   typedef struct {
      mem_t  init;
      mem_t  exp;
      bit    hold;
      bit    pulse;
      int    exp_cyc;
      int    exp_sw;
   } vec_t;

   logic clk, rst, start, AgtB, zi, zj;
   logic EA, EB, Li, Ei, Lj, Ej, Csel, WE, Bout, busy, done;
`ifdef SORT_CTRL_SWAP_CNT_EN
   logic [4:0] swap_cnt;
`endif

   sort_controller #(.K(K)) dut (
      .clk(clk), .rst(rst), .start(start), .AgtB(AgtB), .zi(zi), .zj(zj),
      .EA(EA), .EB(EB), .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej),
      .Csel(Csel), .WE(WE), .Bout(Bout), .busy(busy), .done(done)
`ifdef SORT_CTRL_SWAP_CNT_EN
      , .swap_cnt(swap_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath and memory model.
   mem_t       mem;
   mem_t       load_data;
   logic       load_en = 1'b0;
   logic [7:0] a_reg = '0, b_reg = '0;
   logic [2:0] i_reg = '0, j_reg = '0;
   logic [7:0] dout;

   assign dout = Csel ? mem[j_reg] : mem[i_reg];
   assign AgtB = a_reg > b_reg;
   assign zi   = (i_reg == 3'd6);
   assign zj   = (j_reg == 3'd7);

   always @(posedge clk) begin
      if (load_en) begin
         mem <= load_data;
      end else begin
         if (WE) begin
            if (Csel) mem[j_reg] <= Bout ? b_reg : a_reg;
            else      mem[i_reg] <= Bout ? b_reg : a_reg;
         end
         if (EA) a_reg <= dout;
         if (EB) b_reg <= dout;
         if (Li) i_reg <= 3'd0;
         else if (Ei) i_reg <= 3'(i_reg + 3'd1);
         if (Lj) j_reg <= 3'(i_reg + 3'd1);
         else if (Ej) j_reg <= 3'(j_reg + 3'd1);
      end
   end

   // Protocol monitor: strobe exclusivity and write counting.
   int onehot_viol = 0;
   int wr_i_cnt = 0;
   int we_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         if ($countones({EA, EB, Li, Ei, Lj, Ej, WE}) > 1) onehot_viol <= onehot_viol + 1;
         if (WE && !Csel) wr_i_cnt <= wr_i_cnt + 1;
         if (WE) we_cnt <= we_cnt + 1;
      end
   end

   wire [10:0] ctrl = {EA, EB, Li, Ei, Lj, Ej, Csel, WE, Bout, busy, done};

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic void ref_sort(input mem_t m, output mem_t s, output int sw);
      logic [7:0] a;
      sw = 0;
      for (int i = 0; i < K - 1; i++) begin
         a = m[i];
         for (int j = i + 1; j < K; j++) begin
            if (a > m[j]) begin
               m[i] = m[j];
               m[j] = a;
               a    = m[i];
               sw++;
            end
         end
      end
      s = m;
   endfunction

   task automatic run_sort(input string tag, input bit do_load, input mem_t init, input mem_t exp,
                           input bit hold, input bit pulse, input int exp_cyc, input int exp_sw);
      int cycles, wr0, we0;
      if (do_load) begin
         @(negedge clk);
         load_data = init;
         load_en   = 1'b1;
         @(negedge clk);
         load_en   = 1'b0;
      end
      @(negedge clk);
      wr0   = wr_i_cnt;
      we0   = we_cnt;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      cycles = 0;
      while (cycles < 1000) begin
         @(posedge clk);
         #1;
         cycles++;
         if (pulse) start = (cycles == 30);
         if (done) break;
      end
      check({tag, "_cycles"}, 32'(cycles), 32'(exp_cyc));
      @(negedge clk);
      check({tag, "_swaps"}, 32'(wr_i_cnt - wr0), 32'(exp_sw));
      check({tag, "_writes"}, 32'(we_cnt - we0), 32'(2 * exp_sw));
`ifdef SORT_CTRL_SWAP_CNT_EN
      check({tag, "_swap_cnt"}, 32'(swap_cnt), 32'(exp_sw));
`endif
      for (int k = 0; k < K; k++) check($sformatf("%s_mem%0d", tag, k), 32'(mem[k]), 32'(exp[k]));
      if (hold) begin
         repeat (3) @(posedge clk);
         #1;
         check({tag, "_hold_done"}, 32'(ctrl), 32'h001);
         @(negedge clk);
         start = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, "_back_idle"}, 32'(ctrl), 32'h000);
   endtask

   vec_t vecs[4];
   mem_t snap, exp_m, dummy;
   int   sw, nwrj;

   initial begin
      vecs[0] = '{init: '{10, 15, 25, 30, 45, 60, 75, 90}, exp: '{10, 15, 25, 30, 45, 60, 75, 90},
                  hold: 1'b0, pulse: 1'b0, exp_cyc: 106, exp_sw: 0};
      vecs[1] = '{init: '{8, 7, 6, 5, 4, 3, 2, 1}, exp: '{1, 2, 3, 4, 5, 6, 7, 8},
                  hold: 1'b0, pulse: 1'b0, exp_cyc: 190, exp_sw: 28};
      vecs[2] = '{init: '{90, 25, 60, 15, 30, 75, 45, 10}, exp: '{10, 15, 25, 30, 45, 60, 75, 90},
                  hold: 1'b0, pulse: 1'b1, exp_cyc: 160, exp_sw: 18};
      vecs[3] = '{init: '{90, 25, 60, 15, 30, 75, 45, 10}, exp: '{10, 15, 25, 30, 45, 60, 75, 90},
                  hold: 1'b1, pulse: 1'b0, exp_cyc: 160, exp_sw: 18};
      dummy = '{default: 8'd0};

      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'(ctrl), 32'h000);
      @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 4; v++)
         run_sort($sformatf("vec%0d", v), 1'b1, vecs[v].init, vecs[v].exp,
                  vecs[v].hold, vecs[v].pulse, vecs[v].exp_cyc, vecs[v].exp_sw);

      // Reset landing in the third WR_J cycle, then idle hold, then re-sort of the leftover data.
      @(negedge clk);
      load_data = vecs[1].init;
      load_en   = 1'b1;
      @(negedge clk);
      load_en   = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nwrj  = 0;
      for (int c = 0; c < 400 && nwrj < 3; c++) begin
         @(negedge clk);
         if (WE && Csel) nwrj++;
      end
      check("found_wr_j3", 32'(nwrj), 32'd3);
      rst = 1'b0;
      #1;
      check("rst_async_outputs", 32'(ctrl), 32'h000);
      snap = mem;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("idle_outputs%0d", c), 32'(ctrl), 32'h000);
      end
      check("mem_untouched", 32'(mem == snap), 32'd1);
      ref_sort(snap, exp_m, sw);
      run_sort("resort", 1'b0, dummy, exp_m, 1'b0, 1'b0, 106 + 3 * sw, sw);

      check("onehot_strobes", 32'(onehot_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
